// File: rtl/vga_pattern_gen.sv
// Test-pattern colour stage for a 640x480 VGA timing chain: 2-cycle pipeline to RGB/hs/vs.
// Define VGA_PATTERN_BORDER_EN to add a 1-pixel white frame around the active area.
module vga_pattern_gen #(
   parameter int unsigned AUTO_FRAMES = 120,
   parameter int unsigned BOX_SIZE    = 32,
   parameter int unsigned BOX_STEP    = 2,
   parameter int unsigned CHK_SHIFT   = 5
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       pix_en_i,
   input  logic [9:0] hcount_i,
   input  logic [9:0] vcount_i,
   input  logic       blank_i,
   input  logic       hsync_i,
   input  logic       vsync_i,
   input  logic       mode_next_i,
   output logic       hs_o,
   output logic       vs_o,
   output logic [3:0] red_o,
   output logic [3:0] green_o,
   output logic [3:0] blue_o,
   output logic [1:0] mode_o
);

   localparam logic [9:0] X_LIM   = 10'(640 - BOX_SIZE);
   localparam logic [9:0] Y_LIM   = 10'(480 - BOX_SIZE);
   localparam logic [9:0] STEP    = 10'(BOX_STEP);
   localparam logic [9:0] SIZE    = 10'(BOX_SIZE);
   localparam bit         AUTO_EN = (AUTO_FRAMES != 0);
   localparam logic [7:0] AUTO_TC = AUTO_EN ? 8'(AUTO_FRAMES - 1) : 8'd0;

   // The pipeline advances every clock, so the pixel strobe carries no information here.
   logic unused_pix_en;
   assign unused_pix_en = pix_en_i;

   logic [9:0]  h1_q, h1_d, v1_q, v1_d;
   logic        bl1_q, bl1_d, hs1_q, hs1_d, vs1_q, vs1_d;
   logic [1:0]  mode1_q, mode1_d;
   logic [11:0] rgb_q, rgb_d;
   logic        hs2_q, hs2_d, vs2_q, vs2_d;
   logic [1:0]  mode_q, mode_d;
   logic        pend_q, pend_d;
   logic [7:0]  fc_q, fc_d;
   logic [9:0]  bx_q, bx_d, by_q, by_d;
   logic        dx_q, dx_d, dy_q, dy_d;

   logic        frame_evt;
   logic [7:0]  fc_base;
   logic        in_box;

   assign frame_evt = vs1_q & ~vsync_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         h1_q    <= '0;
         v1_q    <= '0;
         bl1_q   <= 1'b1;
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
         mode1_q <= '0;
         rgb_q   <= '0;
         hs2_q   <= 1'b1;
         vs2_q   <= 1'b1;
         mode_q  <= '0;
         pend_q  <= 1'b0;
         fc_q    <= '0;
         bx_q    <= '0;
         by_q    <= '0;
         dx_q    <= 1'b1;
         dy_q    <= 1'b1;
      end else begin
         h1_q    <= h1_d;
         v1_q    <= v1_d;
         bl1_q   <= bl1_d;
         hs1_q   <= hs1_d;
         vs1_q   <= vs1_d;
         mode1_q <= mode1_d;
         rgb_q   <= rgb_d;
         hs2_q   <= hs2_d;
         vs2_q   <= vs2_d;
         mode_q  <= mode_d;
         pend_q  <= pend_d;
         fc_q    <= fc_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
      end
   end

   always_comb begin
      h1_d    = hcount_i;
      v1_d    = vcount_i;
      bl1_d   = blank_i;
      hs1_d   = hsync_i;
      vs1_d   = vsync_i;
      mode1_d = mode_q;
      hs2_d   = hs1_q;
      vs2_d   = vs1_q;
   end

   always_comb begin
      mode_d  = mode_q;
      pend_d  = pend_q | mode_next_i;
      fc_d    = fc_q;
      bx_d    = bx_q;
      by_d    = by_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      fc_base = pend_q ? 8'd0 : fc_q + 8'd1;
      if (frame_evt) begin
         if (pend_q) begin
            mode_d = mode_q + 2'd1;
            pend_d = mode_next_i;
         end
         fc_d = fc_base;
         // Terminal count is one early: the advance itself consumes a frame event,
         // so each pattern is still shown for AUTO_FRAMES frames.
         if (AUTO_EN && (fc_base >= AUTO_TC)) begin
            fc_d   = 8'd0;
            pend_d = 1'b1;
         end
         if (mode_q == 2'd3) begin
            if (dx_q) begin
               bx_d = bx_q + STEP;
               if (bx_q + STEP >= X_LIM) begin
                  bx_d = X_LIM;
                  dx_d = 1'b0;
               end
            end else if (bx_q <= STEP) begin
               bx_d = 10'd0;
               dx_d = 1'b1;
            end else begin
               bx_d = bx_q - STEP;
            end
            if (dy_q) begin
               by_d = by_q + STEP;
               if (by_q + STEP >= Y_LIM) begin
                  by_d = Y_LIM;
                  dy_d = 1'b0;
               end
            end else if (by_q <= STEP) begin
               by_d = 10'd0;
               dy_d = 1'b1;
            end else begin
               by_d = by_q - STEP;
            end
         end
      end
   end

   assign in_box = (h1_q >= bx_q) && (h1_q < bx_q + SIZE) &&
                   (v1_q >= by_q) && (v1_q < by_q + SIZE);

   always_comb begin
      rgb_d = 12'h000;
      case (mode1_q)
         2'd0: begin
            if      (h1_q < 10'd80)  rgb_d = 12'hFFF;
            else if (h1_q < 10'd160) rgb_d = 12'hFF0;
            else if (h1_q < 10'd240) rgb_d = 12'h0FF;
            else if (h1_q < 10'd320) rgb_d = 12'h0F0;
            else if (h1_q < 10'd400) rgb_d = 12'hF0F;
            else if (h1_q < 10'd480) rgb_d = 12'hF00;
            else if (h1_q < 10'd560) rgb_d = 12'h00F;
            else                     rgb_d = 12'h000;
         end
         2'd1:    rgb_d = (h1_q[CHK_SHIFT] ^ v1_q[CHK_SHIFT]) ? 12'hFFF : 12'h000;
         2'd2:    rgb_d = {h1_q[9:6], v1_q[8:5], fc_q[5:2]};
         default: rgb_d = in_box ? 12'hFFF : 12'h008;
      endcase
`ifdef VGA_PATTERN_BORDER_EN
      if ((h1_q == 10'd0) || (h1_q == 10'd639) || (v1_q == 10'd0) || (v1_q == 10'd479))
         rgb_d = 12'hFFF;
`endif
      if (bl1_q) rgb_d = 12'h000;
   end

   assign red_o   = rgb_q[11:8];
   assign green_o = rgb_q[7:4];
   assign blue_o  = rgb_q[3:0];
   assign hs_o    = hs2_q;
   assign vs_o    = vs2_q;
   assign mode_o  = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: expected pixels queued at drive time, compared 2 cycles later.
module tb_vga_pattern_gen;

   logic       clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0;
   logic       blank = 1'b1, hsync = 1'b1, vsync = 1'b1, mode_next = 1'b0;
   logic [9:0] hcount = '0, vcount = '0;
   logic       hs_o, vs_o;
   logic [3:0] red, green, blue;
   logic [1:0] mode, mode_a;
   logic [13:0] auto_unused_bus;

   int n_total = 0;
   int n_pass  = 0;

`ifdef VGA_PATTERN_BORDER_EN
   localparam bit BORDER = 1'b1;
`else
   localparam bit BORDER = 1'b0;
`endif

   typedef struct {
      logic        chk;
      logic [11:0] rgb;
      logic        hs, vs;
      logic [9:0]  h, v;
   } exp_t;

   typedef struct {
      logic [9:0]  h, v;
      logic        bl, hs, mn, chk;
      logic [11:0] rgb;
   } stim_t;

   exp_t  exp_q[$];
   stim_t sq[$];

   always #5 clk = ~clk;

   vga_pattern_gen #(.AUTO_FRAMES(0)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .pix_en_i(pix_en), .hcount_i(hcount), .vcount_i(vcount),
      .blank_i(blank), .hsync_i(hsync), .vsync_i(vsync), .mode_next_i(mode_next),
      .hs_o(hs_o), .vs_o(vs_o), .red_o(red), .green_o(green), .blue_o(blue), .mode_o(mode)
   );

   vga_pattern_gen #(.AUTO_FRAMES(2)) dut_auto (
      .clk_i(clk), .rst_n_i(rst_n), .pix_en_i(pix_en), .hcount_i(hcount), .vcount_i(vcount),
      .blank_i(blank), .hsync_i(hsync), .vsync_i(vsync), .mode_next_i(mode_next),
      .hs_o(auto_unused_bus[0]), .vs_o(auto_unused_bus[1]), .red_o(auto_unused_bus[5:2]),
      .green_o(auto_unused_bus[9:6]), .blue_o(auto_unused_bus[13:10]), .mode_o(mode_a)
   );

   task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic bl, input logic hs,
                        input logic vs, input logic mn, input logic chk, input logic [11:0] rgb);
      exp_t e;
      @(negedge clk);
      hcount = h; vcount = v; blank = bl; hsync = hs; vsync = vs; mode_next = mn;
      pix_en = ~pix_en;
      e.chk = chk; e.rgb = rgb; e.hs = hs; e.vs = vs; e.h = h; e.v = v;
      exp_q.push_back(e);
   endtask

   task automatic add(input logic [9:0] h, input logic [9:0] v, input logic bl, input logic hs,
                      input logic mn, input logic chk, input logic [11:0] rgb);
      stim_t s;
      s.h = h; s.v = v; s.bl = bl; s.hs = hs; s.mn = mn; s.chk = chk; s.rgb = rgb;
      sq.push_back(s);
   endtask

   task automatic add_idle();
      add(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
      add(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
   endtask

   task automatic frame_evt();
      drive(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
      drive(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
   endtask

   task automatic request();
      drive(10'd5, 10'd100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
   endtask

   task automatic release_reset();
      exp_t e;
      @(negedge clk);
      rst_n = 1'b1; hsync = 1'b0; vsync = 1'b1; blank = 1'b1; mode_next = 1'b0;
      exp_q.delete();
      e.chk = 1'b1; e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1; e.h = 10'd0; e.v = 10'd0;
      exp_q.push_back(e);
      e.hs = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_total++;
      if ({red, green, blue, hs_o, vs_o, mode, mode_a} !== {12'h000, 1'b1, 1'b1, 2'd0, 2'd0})
         $display("FAIL reset_state: rgb/hs/vs/mode/mode_a got %h/%b/%b/%0d/%0d want 000/1/1/0/0",
                  {red, green, blue}, hs_o, vs_o, mode, mode_a);
      else n_pass++;
      release_reset();
   endtask

   task automatic test_bars();
      stim_t s; exp_t e;
      add(0,   10, 0, 1, 0, 1, 12'hFFF);
      add(79,  10, 0, 0, 0, 1, 12'hFFF);
      add(80,  10, 0, 1, 0, 1, 12'hFF0);
      add(85,  10, 0, 0, 0, 1, 12'hFF0);
      add(160, 10, 0, 0, 0, 1, 12'h0FF);
      add(240, 10, 0, 1, 0, 1, 12'h0F0);
      add(320, 10, 0, 1, 0, 1, 12'hF0F);
      add(400, 10, 0, 0, 0, 1, 12'hF00);
      add(480, 10, 0, 1, 0, 1, 12'h00F);
      add(560, 10, 0, 1, 0, 1, 12'h000);
      add(639, 10, 0, 0, 0, 1, BORDER ? 12'hFFF : 12'h000);
      add(700, 10, 1, 0, 0, 1, 12'h000);
      add(700, 10, 1, 1, 0, 1, 12'h000);
      add_idle();
      while (sq.size() != 0) begin
         s = sq.pop_front();
         drive(s.h, s.v, s.bl, s.hs, 1'b1, s.mn, s.chk, s.rgb);
         while (exp_q.size() > 3) void'(exp_q.pop_front());
         if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            n_total++;
            if ({hs_o, vs_o} !== {e.hs, e.vs})
               $display("FAIL bars_sync h=%0d: hs/vs got %b%b want %b%b", e.h, hs_o, vs_o, e.hs, e.vs);
            else n_pass++;
            if (e.chk) begin
               n_total++;
               if ({red, green, blue} !== e.rgb)
                  $display("FAIL bars_rgb h=%0d: got %h want %h", e.h, {red, green, blue}, e.rgb);
               else n_pass++;
            end
         end
      end
   endtask

   task automatic test_manual_advance();
      stim_t s; exp_t e;
      add(85,  100, 0, 1, 1, 1, 12'hFF0);
      add(160, 100, 0, 1, 0, 1, 12'h0FF);
      add(0,   101, 0, 1, 0, 1, 12'hFFF);
      add_idle();
      while (sq.size() != 0) begin
         s = sq.pop_front();
         drive(s.h, s.v, s.bl, s.hs, 1'b1, s.mn, s.chk, s.rgb);
         while (exp_q.size() > 3) void'(exp_q.pop_front());
         if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            if (e.chk) begin
               n_total++;
               if ({red, green, blue} !== e.rgb)
                  $display("FAIL manual_rgb h=%0d: got %h want %h", e.h, {red, green, blue}, e.rgb);
               else n_pass++;
            end
         end
      end
      n_total++;
      if (mode !== 2'd0) $display("FAIL manual_hold: mode_o got %0d want 0", mode);
      else n_pass++;
      frame_evt();
      n_total++;
      if (mode !== 2'd1) $display("FAIL manual_apply: mode_o got %0d want 1", mode);
      else n_pass++;
   endtask

   task automatic test_checker();
      stim_t s; exp_t e;
      add(32,  10,  0, 1, 0, 1, 12'hFFF);
      add(10,  10,  0, 1, 0, 1, 12'h000);
      add(40,  40,  0, 0, 0, 1, 12'h000);
      add(10,  40,  0, 1, 0, 1, 12'hFFF);
      add(100, 200, 0, 1, 0, 1, 12'hFFF);
      add(700, 40,  1, 1, 0, 1, 12'h000);
      add_idle();
      while (sq.size() != 0) begin
         s = sq.pop_front();
         drive(s.h, s.v, s.bl, s.hs, 1'b1, s.mn, s.chk, s.rgb);
         while (exp_q.size() > 3) void'(exp_q.pop_front());
         if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            if (e.chk) begin
               n_total++;
               if ({red, green, blue} !== e.rgb)
                  $display("FAIL checker_rgb h=%0d v=%0d: got %h want %h", e.h, e.v, {red, green, blue}, e.rgb);
               else n_pass++;
            end
         end
      end
   endtask

   task automatic test_multi_request();
      repeat (3) begin
         request();
         drive(10'd0, 10'd100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
      end
      n_total++;
      if (mode !== 2'd1) $display("FAIL multi_hold: mode_o got %0d want 1", mode);
      else n_pass++;
      frame_evt();
      n_total++;
      if (mode !== 2'd2) $display("FAIL multi_apply: mode_o got %0d want 2", mode);
      else n_pass++;
      frame_evt();
      n_total++;
      if (mode !== 2'd2) $display("FAIL multi_single: mode_o got %0d want 2", mode);
      else n_pass++;
   endtask

   task automatic test_gradient();
      stim_t s; exp_t e;
      for (int ph = 0; ph < 2; ph++) begin
         add(448, 96, 0, 1, 0, 1, (ph == 0) ? 12'h730 : 12'h731);
         add(64,  32, 0, 0, 0, 1, (ph == 0) ? 12'h110 : 12'h111);
         add(448, 96, 1, 1, 0, 1, 12'h000);
         add_idle();
         while (sq.size() != 0) begin
            s = sq.pop_front();
            drive(s.h, s.v, s.bl, s.hs, 1'b1, s.mn, s.chk, s.rgb);
            while (exp_q.size() > 3) void'(exp_q.pop_front());
            if (exp_q.size() == 3) begin
               e = exp_q.pop_front();
               if (e.chk) begin
                  n_total++;
                  if ({red, green, blue} !== e.rgb)
                     $display("FAIL gradient_rgb ph=%0d h=%0d: got %h want %h", ph, e.h, {red, green, blue}, e.rgb);
                  else n_pass++;
               end
            end
         end
         if (ph == 0) repeat (4) frame_evt();
      end
   endtask

   task automatic test_coincident();
      drive(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
      drive(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
      n_total++;
      if (mode !== 2'd2) $display("FAIL coincident_hold: mode_o got %0d want 2", mode);
      else n_pass++;
      frame_evt();
      n_total++;
      if (mode !== 2'd3) $display("FAIL coincident_apply: mode_o got %0d want 3", mode);
      else n_pass++;
   endtask

   task automatic test_box();
      stim_t s; exp_t e;
      for (int ph = 0; ph < 4; ph++) begin
         case (ph)
            0: begin
               add(5, 5, 0, 1, 0, 1, 12'hFFF);   add(31, 31, 0, 1, 0, 1, 12'hFFF);
               add(32, 5, 0, 1, 0, 1, 12'h008);  add(5, 32, 0, 1, 0, 1, 12'h008);
            end
            1: begin
               add(3, 3, 0, 1, 0, 1, 12'hFFF);   add(1, 1, 0, 1, 0, 1, 12'h008);
               add(33, 33, 0, 1, 0, 1, 12'hFFF); add(34, 10, 0, 1, 0, 1, 12'h008);
            end
            2: begin
               add(608, 288, 0, 1, 0, 1, 12'hFFF); add(607, 288, 0, 1, 0, 1, 12'h008);
               add(608, 287, 0, 1, 0, 1, 12'h008); add(638, 318, 0, 1, 0, 1, 12'hFFF);
            end
            default: begin
               add(606, 286, 0, 1, 0, 1, 12'hFFF); add(605, 286, 0, 1, 0, 1, 12'h008);
               add(637, 317, 0, 1, 0, 1, 12'hFFF); add(638, 317, 0, 1, 0, 1, 12'h008);
            end
         endcase
         add_idle();
         while (sq.size() != 0) begin
            s = sq.pop_front();
            drive(s.h, s.v, s.bl, s.hs, 1'b1, s.mn, s.chk, s.rgb);
            while (exp_q.size() > 3) void'(exp_q.pop_front());
            if (exp_q.size() == 3) begin
               e = exp_q.pop_front();
               if (e.chk) begin
                  n_total++;
                  if ({red, green, blue} !== e.rgb)
                     $display("FAIL box_rgb ph=%0d (%0d,%0d): got %h want %h", ph, e.h, e.v, {red, green, blue}, e.rgb);
                  else n_pass++;
               end
            end
         end
         if (ph == 0 || ph == 2) frame_evt();
         else if (ph == 1) repeat (303) frame_evt();
      end
   endtask

   task automatic test_reset_mid();
      stim_t s; exp_t e;
      repeat (3) begin
         request();
         frame_evt();
      end
      n_total++;
      if (mode !== 2'd2) $display("FAIL pre_reset_mode: mode_o got %0d want 2", mode);
      else n_pass++;
      repeat (4) drive(10'd448, 10'd96, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({red, green, blue, hs_o, vs_o, mode} !== {12'h000, 1'b1, 1'b1, 2'd0})
         $display("FAIL reset_mid: rgb/hs/vs/mode got %h/%b/%b/%0d want 000/1/1/0",
                  {red, green, blue}, hs_o, vs_o, mode);
      else n_pass++;
      release_reset();
      add(85,  200, 0, 1, 0, 1, 12'hFF0);
      add(480, 200, 0, 0, 0, 1, 12'h00F);
      add_idle();
      while (sq.size() != 0) begin
         s = sq.pop_front();
         drive(s.h, s.v, s.bl, s.hs, 1'b1, s.mn, s.chk, s.rgb);
         while (exp_q.size() > 3) void'(exp_q.pop_front());
         if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            n_total++;
            if ({hs_o, vs_o} !== {e.hs, e.vs})
               $display("FAIL release_sync h=%0d: hs/vs got %b%b want %b%b", e.h, hs_o, vs_o, e.hs, e.vs);
            else n_pass++;
            if (e.chk) begin
               n_total++;
               if ({red, green, blue} !== e.rgb)
                  $display("FAIL release_rgb h=%0d: got %h want %h", e.h, {red, green, blue}, e.rgb);
               else n_pass++;
            end
         end
      end
   endtask

   task automatic test_auto();
      logic [1:0] exp_m;
      n_total++;
      if (mode_a !== 2'd0) $display("FAIL auto_start: mode_o got %0d want 0", mode_a);
      else n_pass++;
      for (int i = 1; i <= 8; i++) begin
         frame_evt();
         exp_m = 2'((i / 2) % 4);
         n_total++;
         if (mode_a !== exp_m) $display("FAIL auto_seq frame=%0d: mode_o got %0d want %0d", i, mode_a, exp_m);
         else n_pass++;
      end
      n_total++;
      if (mode !== 2'd0) $display("FAIL auto_disabled: mode_o got %0d want 0", mode);
      else n_pass++;
   endtask

`ifdef VGA_PATTERN_BORDER_EN
   task automatic test_border();
      stim_t s; exp_t e;
      for (int m = 0; m < 4; m++) begin
         add(0, 240, 0, 1, 0, 1, 12'hFFF);
         add(300, 479, 0, 1, 0, 1, 12'hFFF);
         add_idle();
         while (sq.size() != 0) begin
            s = sq.pop_front();
            drive(s.h, s.v, s.bl, s.hs, 1'b1, s.mn, s.chk, s.rgb);
            while (exp_q.size() > 3) void'(exp_q.pop_front());
            if (exp_q.size() == 3) begin
               e = exp_q.pop_front();
               if (e.chk) begin
                  n_total++;
                  if ({red, green, blue} !== e.rgb)
                     $display("FAIL border_rgb mode=%0d (%0d,%0d): got %h want %h", m, e.h, e.v, {red, green, blue}, e.rgb);
                  else n_pass++;
               end
            end
         end
         request();
         frame_evt();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_bars();
      test_manual_advance();
      test_checker();
      test_multi_request();
      test_gradient();
      test_coincident();
      test_box();
      test_reset_mid();
      test_auto();
`ifdef VGA_PATTERN_BORDER_EN
      test_border();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
